// File: rtl/etapa_fetch.sv
// etapa_fetch: instruction-fetch stage with PC, imem req/ready handshake, one-entry skid and IF/ID register.
// Define FETCH_PERF_COUNTERS_EN to add o_fetch_count / o_bubble_count.
module etapa_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          PC_STEP   = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_stall,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_address,
  output logic        o_imem_req,
  output logic [31:0] o_imem_address,
  input  logic        i_imem_ready,
  input  logic [31:0] i_imem_data,
  output logic [31:0] o_instruction,
  output logic [31:0] o_address_pc,
`ifdef FETCH_PERF_COUNTERS_EN
  output logic        o_valid,
  output logic [31:0] o_fetch_count,
  output logic [31:0] o_bubble_count
`else
  output logic        o_valid
`endif
);
  typedef enum logic [1:0] {S_BOOT, S_REQ, S_HOLD} state_t;
  state_t state, state_n;
  logic [31:0] pc, pc_n, pc_next, instr_n, addr_n, skid_instr, skid_addr, skid_instr_n, skid_addr_n;
  logic valid_n, done;
  assign o_imem_req = state == S_REQ;
  assign o_imem_address = pc;
  assign done = o_imem_req & i_imem_ready;
  assign pc_next = pc + 32'(PC_STEP);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_BOOT;
      pc <= RESET_PC;
      o_instruction <= NOP_INSTR;
      o_address_pc <= '0;
      o_valid <= 1'b0;
      skid_instr <= '0;
      skid_addr <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      o_instruction <= instr_n;
      o_address_pc <= addr_n;
      o_valid <= valid_n;
      skid_instr <= skid_instr_n;
      skid_addr <= skid_addr_n;
    end
  end
  // A redirect wins over everything: any word completing this cycle and any skid content are dropped.
  always_comb begin
    state_n = state;
    pc_n = pc;
    instr_n = o_instruction;
    addr_n = o_address_pc;
    valid_n = o_valid;
    skid_instr_n = skid_instr;
    skid_addr_n = skid_addr;
    if (i_branch_taken) begin
      state_n = S_REQ;
      pc_n = i_branch_address;
      instr_n = NOP_INSTR;
      valid_n = 1'b0;
    end else begin
      case (state)
        S_BOOT: state_n = S_REQ;
        S_REQ: begin
          if (done) pc_n = pc_next;
          if (done && i_stall) begin
            skid_instr_n = i_imem_data;
            skid_addr_n = pc_next;
            state_n = S_HOLD;
          end else if (!i_stall) begin
            instr_n = done ? i_imem_data : NOP_INSTR;
            addr_n = done ? pc_next : o_address_pc;
            valid_n = done;
          end
        end
        S_HOLD: if (!i_stall) begin
          instr_n = skid_instr;
          addr_n = skid_addr;
          valid_n = 1'b1;
          state_n = S_REQ;
        end
        default: state_n = S_BOOT;
      endcase
    end
  end
`ifdef FETCH_PERF_COUNTERS_EN
  logic fetch_ev, bubble_ev;
  assign fetch_ev = done & ~i_branch_taken;
  assign bubble_ev = i_branch_taken | (o_imem_req & ~i_imem_ready & ~i_stall);
  always_ff @(posedge clk) begin
    if (reset) begin
      o_fetch_count <= '0;
      o_bubble_count <= '0;
    end else begin
      o_fetch_count <= o_fetch_count + 32'(fetch_ev);
      o_bubble_count <= o_bubble_count + 32'(bubble_ev);
    end
  end
`endif
endmodule

// File: tb/tb_etapa_fetch.sv
// tb_etapa_fetch: directed plus random stimulus against a cycle-level behavioural model of the fetch stage.
module tb_etapa_fetch;
  logic clk = 0, reset = 1, i_stall = 0, i_branch_taken = 0, i_imem_ready = 0;
  logic [31:0] i_branch_address = 0, i_imem_data;
  logic o_imem_req, o_valid;
  logic [31:0] o_imem_address, o_instruction, o_address_pc;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] o_fetch_count, o_bubble_count;
`endif
  etapa_fetch dut (
    .clk(clk), .reset(reset), .i_stall(i_stall), .i_branch_taken(i_branch_taken),
    .i_branch_address(i_branch_address), .o_imem_req(o_imem_req), .o_imem_address(o_imem_address),
    .i_imem_ready(i_imem_ready), .i_imem_data(i_imem_data), .o_instruction(o_instruction),
    .o_address_pc(o_address_pc), .o_valid(o_valid)
`ifdef FETCH_PERF_COUNTERS_EN
    , .o_fetch_count(o_fetch_count), .o_bubble_count(o_bubble_count)
`endif
  );
  always #5 clk = ~clk;
  // Memory returns each word equal to its own address.
  assign i_imem_data = o_imem_address;
  int total = 0, passed = 0;
  bit m_live = 0, m_boot = 1, m_hold = 0, m_valid = 0;
  logic [31:0] m_pc = 0, m_ins = 0, m_addr = 0, m_skid_i = 0, m_skid_a = 0, m_fc = 0, m_bc = 0;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic model(bit rs, bit st, bit rd, bit br, logic [31:0] ba);
    if (rs) begin
      m_pc = 0; m_boot = 1; m_hold = 0; m_ins = 0; m_addr = 0; m_valid = 0; m_fc = 0; m_bc = 0;
    end else if (br) begin
      m_pc = ba; m_boot = 0; m_hold = 0; m_ins = 0; m_valid = 0; m_bc++;
    end else if (m_boot) m_boot = 0;
    else if (m_hold) begin
      if (!st) begin m_ins = m_skid_i; m_addr = m_skid_a; m_valid = 1; m_hold = 0; end
    end else if (rd) begin
      if (st) begin m_skid_i = m_pc; m_skid_a = m_pc + 4; m_hold = 1; end
      else begin m_ins = m_pc; m_addr = m_pc + 4; m_valid = 1; end
      m_pc = m_pc + 4; m_fc++;
    end else if (!st) begin
      m_ins = 0; m_valid = 0; m_bc++;
    end
  endtask
  task automatic step(bit rs, bit st, bit rd, bit br, logic [31:0] ba);
    @(negedge clk);
    reset = rs; i_stall = st; i_imem_ready = rd; i_branch_taken = br; i_branch_address = ba;
    #1;
    if (m_live) begin
      chk("imem_req", {31'b0, o_imem_req}, {31'b0, !m_boot && !m_hold});
      chk("imem_address", o_imem_address, m_pc);
    end
    @(posedge clk);
    model(rs, st, rd, br, ba);
    m_live = 1;
    #1;
    chk("instruction", o_instruction, m_ins);
    chk("address_pc", o_address_pc, m_addr);
    chk("valid", {31'b0, o_valid}, {31'b0, m_valid});
`ifdef FETCH_PERF_COUNTERS_EN
    chk("fetch_count", o_fetch_count, m_fc);
    chk("bubble_count", o_bubble_count, m_bc);
`endif
  endtask
  initial begin
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    repeat (5) step(0, 0, 1, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 0, i % 3 == 2, 0, 0);
    step(0, 1, 1, 0, 0);
    repeat (3) step(0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 32'h200);
    repeat (3) step(0, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 0, 1, 32'h40);
    repeat (2) step(0, 0, 1, 0, 0);
    step(1, 0, 1, 1, 32'h80);
    repeat (2) step(0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 32'hFFFF_FFFC);
    repeat (2) step(0, 0, 1, 0, 0);
    for (int i = 0; i < 400; i++)
      step($urandom % 64 == 0, $urandom % 4 == 0, $urandom % 2 == 0, $urandom % 16 == 0,
           $urandom & 32'hFFFF_FFFC);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
